// File: rtl/mdu_pkg.sv
// Shared MDU operation encodings and FSM state type, used by the decoder,
// the hazard controller and the execute-stage multiply/divide unit.
package mdu_pkg;

  localparam int MDU_OP_SIZE = 4;

  typedef enum logic [MDU_OP_SIZE-1:0] {
    MDU_OP_NONE  = 4'd0,
    MDU_OP_MULT  = 4'd1,
    MDU_OP_MULTU = 4'd2,
    MDU_OP_DIV   = 4'd3,
    MDU_OP_DIVU  = 4'd4,
    MDU_OP_MFHI  = 4'd5,
    MDU_OP_MFLO  = 4'd6,
    MDU_OP_MTHI  = 4'd7,
    MDU_OP_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  function automatic logic is_start_op(input logic [MDU_OP_SIZE-1:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
           (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [MDU_OP_SIZE-1:0] op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu.sv
// Execute-stage multiply/divide unit holding HI/LO. A mult/div started in cycle t
// keeps E_MDU_busy high for t..t+N and its result is readable from t+N+1.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [MDU_OP_SIZE-1:0] E_MDU_op,
  input  logic [31:0]            E_MDU_A,
  input  logic [31:0]            E_MDU_B,
  input  logic                   req,
  output logic                   E_MDU_busy,
  output logic [31:0]            E_MDU_out
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  mdu_state_e     state, state_nxt;
  logic [CW-1:0]  cnt;
  logic           busy_reg;
  logic [31:0]    hi, lo;
  logic [31:0]    pend_hi, pend_lo;
  logic           pend_we;
  logic           start;
  logic           last;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               div_ovf;
  logic signed [31:0] sdiv_b;
  logic signed [31:0] sdiv_q, sdiv_r;
  logic        [31:0] udiv_b;
  logic        [31:0] udiv_q, udiv_r;
  logic        [31:0] res_hi, res_lo;

  assign start      = is_start_op(E_MDU_op) && !req && (state == MDU_IDLE);
  assign last       = (state == MDU_BUSY) && (cnt == CW'(1));
  assign E_MDU_busy = start || busy_reg;

  // Divisor is forced to 1 for /0 (result discarded) and for MIN/-1, where
  // dividing by 1 yields exactly LO=0x80000000, HI=0.
  assign prod_s  = $signed({{32{E_MDU_A[31]}}, E_MDU_A}) * $signed({{32{E_MDU_B[31]}}, E_MDU_B});
  assign prod_u  = {32'd0, E_MDU_A} * {32'd0, E_MDU_B};
  assign div_ovf = (E_MDU_A == 32'h8000_0000) && (E_MDU_B == 32'hFFFF_FFFF);
  assign sdiv_b  = ((E_MDU_B == 32'd0) || div_ovf) ? 32'sd1 : $signed(E_MDU_B);
  assign sdiv_q  = $signed(E_MDU_A) / sdiv_b;
  assign sdiv_r  = $signed(E_MDU_A) % sdiv_b;
  assign udiv_b  = (E_MDU_B == 32'd0) ? 32'd1 : E_MDU_B;
  assign udiv_q  = E_MDU_A / udiv_b;
  assign udiv_r  = E_MDU_A % udiv_b;

  always_comb begin
    res_hi = prod_s[63:32];
    res_lo = prod_s[31:0];
    case (E_MDU_op)
      MDU_OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MDU_OP_DIV: begin
        res_hi = sdiv_r;
        res_lo = sdiv_q;
      end
      MDU_OP_DIVU: begin
        res_hi = udiv_r;
        res_lo = udiv_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= MDU_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MDU_IDLE: if (start) state_nxt = MDU_BUSY;
      MDU_BUSY: if (last)  state_nxt = MDU_IDLE;
      default:             state_nxt = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      busy_reg <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      pend_hi  <= '0;
      pend_lo  <= '0;
      pend_we  <= 1'b0;
    end else if (state == MDU_IDLE) begin
      if (start) begin
        cnt      <= is_div_op(E_MDU_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        busy_reg <= 1'b1;
        pend_hi  <= res_hi;
        pend_lo  <= res_lo;
        pend_we  <= !(is_div_op(E_MDU_op) && (E_MDU_B == 32'd0));
      end else if (!req && (E_MDU_op == MDU_OP_MTHI)) begin
        hi <= E_MDU_A;
      end else if (!req && (E_MDU_op == MDU_OP_MTLO)) begin
        lo <= E_MDU_A;
      end
    end else begin
      // Illegal start/MT ops arriving here are ignored; the in-flight op runs on.
      cnt <= cnt - CW'(1);
      if (last) begin
        busy_reg <= 1'b0;
        if (pend_we) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end
    end
  end

  always_comb begin
    E_MDU_out = 32'd0;
    if (E_MDU_op == MDU_OP_MFHI)      E_MDU_out = hi;
    else if (E_MDU_op == MDU_OP_MFLO) E_MDU_out = lo;
  end

endmodule
